// File: rtl/medyan_cok_kanal.sv
// Multi-lane rank-search median filter with ready/valid on both sides; windows are
// dispatched round-robin and returned in arrival order. MEDYAN_MINMAKS_EN adds mod_i (median/min/max).
module medyan_cok_kanal #(
    parameter int PIXEL_BIT = 8,
    parameter int PENCERE   = 9,
    parameter int KANAL     = 10
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         etkin_i,
    output logic                         hazir_o,
    input  logic [PENCERE*PIXEL_BIT-1:0] resim_i,
    output logic                         etkin_o,
    input  logic                         hazir_i,
    output logic [PIXEL_BIT-1:0]         pixel_o
`ifdef MEDYAN_MINMAKS_EN
    ,
    input  logic [1:0]                   mod_i
`endif
);

    localparam int PW = $clog2(KANAL);
    localparam int CW = $clog2(PENCERE + 1);
    localparam int AW = $clog2(PENCERE);
    localparam logic [CW-1:0] HEDEF_MED = CW'((PENCERE - 1) / 2);
`ifdef MEDYAN_MINMAKS_EN
    localparam logic [CW-1:0] HEDEF_MAKS = CW'(PENCERE - 1);
`endif

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        HESAP = 2'd1,
        DOLU  = 2'd2
    } durum_t;

    logic [PW-1:0]        r_giris;
    logic [PW-1:0]        r_cikis;
    durum_t               w_durum [KANAL];
    logic [PIXEL_BIT-1:0] w_sonuc [KANAL];
    logic                 w_kabul;
    logic                 w_birak;

    // Handshake outputs depend only on lane state and the pointers, never on etkin_i/hazir_i.
    assign hazir_o = (w_durum[r_giris] == BOS);
    assign etkin_o = (w_durum[r_cikis] == DOLU);
    assign pixel_o = etkin_o ? w_sonuc[r_cikis] : '0;
    assign w_kabul = etkin_i && hazir_o;
    assign w_birak = etkin_o && hazir_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_giris <= '0;
            r_cikis <= '0;
        end else begin
            if (w_kabul) begin
                r_giris <= (r_giris == PW'(KANAL - 1)) ? '0 : r_giris + PW'(1);
            end
            if (w_birak) begin
                r_cikis <= (r_cikis == PW'(KANAL - 1)) ? '0 : r_cikis + PW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KANAL; gi++) begin : g_kanal
            durum_t               r_durum;
            logic [PIXEL_BIT-1:0] r_pencere [PENCERE];
            logic [AW-1:0]        r_aday;
            logic [PIXEL_BIT-1:0] r_sonuc;
            logic [PIXEL_BIT-1:0] w_aday_pix;
            logic [CW-1:0]        w_az;
            logic [CW-1:0]        w_esit;
            logic [CW-1:0]        w_hedef;
            logic                 w_bulundu;
            logic                 w_sec_giris;
            logic                 w_sec_cikis;

            assign w_sec_giris = w_kabul && (r_giris == PW'(gi));
            assign w_sec_cikis = w_birak && (r_cikis == PW'(gi));

`ifdef MEDYAN_MINMAKS_EN
            logic [1:0] r_mod;
            always_ff @(posedge clk_i) begin
                if (w_sec_giris) begin
                    r_mod <= mod_i;
                end
            end
            always_comb begin
                case (r_mod)
                    2'd1:    w_hedef = '0;
                    2'd2:    w_hedef = HEDEF_MAKS;
                    default: w_hedef = HEDEF_MED;
                endcase
            end
`else
            assign w_hedef = HEDEF_MED;
`endif

            // Rank of the current candidate: how many pixels are strictly below it and equal to it.
            always_comb begin
                w_aday_pix = r_pencere[r_aday];
                w_az       = '0;
                w_esit     = '0;
                for (int k = 0; k < PENCERE; k++) begin
                    if (r_pencere[k] < w_aday_pix) begin
                        w_az = w_az + CW'(1);
                    end
                    if (r_pencere[k] == w_aday_pix) begin
                        w_esit = w_esit + CW'(1);
                    end
                end
                w_bulundu = (w_az <= w_hedef) && (w_hedef < w_az + w_esit);
            end

            always_ff @(posedge clk_i) begin
                if (w_sec_giris) begin
                    for (int k = 0; k < PENCERE; k++) begin
                        r_pencere[k] <= resim_i[k*PIXEL_BIT +: PIXEL_BIT];
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_durum <= BOS;
                    r_aday  <= '0;
                    r_sonuc <= '0;
                end else begin
                    case (r_durum)
                        BOS: begin
                            if (w_sec_giris) begin
                                r_durum <= HESAP;
                                r_aday  <= '0;
                            end
                        end
                        HESAP: begin
                            if (w_bulundu) begin
                                r_sonuc <= w_aday_pix;
                                r_durum <= DOLU;
                            end else begin
                                r_aday <= r_aday + AW'(1);
                            end
                        end
                        DOLU: begin
                            if (w_sec_cikis) begin
                                r_durum <= BOS;
                            end
                        end
                        default: r_durum <= BOS;
                    endcase
                end
            end

            assign w_durum[gi] = r_durum;
            assign w_sonuc[gi] = r_sonuc;
        end
    endgenerate

endmodule

// File: tb/tb_medyan_cok_kanal.sv
// Directed bench for medyan_cok_kanal: reset, late/early match, backpressure, mid-stream
// reset and a sustained-throughput run on an 11-lane instance.
module tb_medyan_cok_kanal;

    typedef logic [7:0] pen_t [9];

    logic        clk;
    logic        rstn;
    logic        etkin_i, hazir_o, etkin_o, hazir_i;
    logic [71:0] resim;
    logic [7:0]  pixel_o;
    logic        etkin2_i, hazir2_o, etkin2_o, hazir2_i;
    logic [71:0] resim2;
    logic [7:0]  pixel2_o;
`ifdef MEDYAN_MINMAKS_EN
    logic [1:0]  mod_s;
    logic [1:0]  mod2_s;
`endif

    int checks   = 0;
    int failures = 0;

    medyan_cok_kanal u_dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .etkin_i (etkin_i),
        .hazir_o (hazir_o),
        .resim_i (resim),
        .etkin_o (etkin_o),
        .hazir_i (hazir_i),
        .pixel_o (pixel_o)
`ifdef MEDYAN_MINMAKS_EN
        ,
        .mod_i   (mod_s)
`endif
    );

    medyan_cok_kanal #(.PIXEL_BIT(8), .PENCERE(9), .KANAL(11)) u_dut11 (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .etkin_i (etkin2_i),
        .hazir_o (hazir2_o),
        .resim_i (resim2),
        .etkin_o (etkin2_o),
        .hazir_i (hazir2_i),
        .pixel_o (pixel2_o)
`ifdef MEDYAN_MINMAKS_EN
        ,
        .mod_i   (mod2_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] paketle(input pen_t p);
        logic [71:0] v;
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = p[k];
        return v;
    endfunction

    // Sort-based reference, independent of the rank-search structure.
    function automatic logic [7:0] medyan(input pen_t p);
        pen_t s;
        logic [7:0] t;
        s = p;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    // Window n is base+n*16 plus a permutation of 0..8, so its median is base+n*16+4.
    function automatic logic [71:0] sira_pencere(input int base, input int n);
        pen_t p;
        for (int k = 0; k < 9; k++) p[k] = 8'(base + n * 16 + (k * 5) % 9);
        return paketle(p);
    endfunction

    task automatic test_reset();
        checks++;
        if (hazir_o !== 1'b1 || etkin_o !== 1'b0 || pixel_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: hazir_o=%b etkin_o=%b pixel_o=%0d required 1/0/0", hazir_o, etkin_o, pixel_o);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (hazir_o !== 1'b1 || etkin_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: hazir_o=%b etkin_o=%b required 1/0", hazir_o, etkin_o);
        end
        $display("reset: hazir_o=%b etkin_o=%b pixel_o=%0d", hazir_o, etkin_o, pixel_o);
    endtask

    task automatic test_late_match();
        pen_t p;
        logic erken;
        p = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        resim = paketle(p); etkin_i = 1'b1; hazir_i = 1'b1;
        checks++;
        if (hazir_o !== 1'b1) begin
            failures++;
            $display("FAIL late_hazir: hazir_o=%b required 1", hazir_o);
        end
        @(posedge clk); #1;
        etkin_i = 1'b0;
        erken = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (etkin_o !== 1'b0) erken = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (erken !== 1'b0) begin
            failures++;
            $display("FAIL late_early: etkin_o rose before E0+9, required 0");
        end
        checks++;
        if (etkin_o !== 1'b1 || pixel_o !== 8'd5) begin
            failures++;
            $display("FAIL late_result: etkin_o=%b pixel_o=%0d required 1/5", etkin_o, pixel_o);
        end
        $display("late_match: pixel_o=%0d", pixel_o);
        @(posedge clk); #1;
        checks++;
        if (etkin_o !== 1'b0 || pixel_o !== 8'd0) begin
            failures++;
            $display("FAIL late_hold: etkin_o=%b pixel_o=%0d required 0/0", etkin_o, pixel_o);
        end
    endtask

    task automatic test_duplicates();
        pen_t p;
        for (int k = 0; k < 9; k++) p[k] = 8'h80;
        p[3] = 8'h00; p[5] = 8'hFF;
        resim = paketle(p); etkin_i = 1'b1; hazir_i = 1'b1;
        @(posedge clk); #1;
        etkin_i = 1'b0;
        checks++;
        if (etkin_o !== 1'b0) begin
            failures++;
            $display("FAIL dup_e0: etkin_o=%b required 0", etkin_o);
        end
        @(posedge clk); #1;
        checks++;
        if (etkin_o !== 1'b1 || pixel_o !== 8'h80) begin
            failures++;
            $display("FAIL dup_result: etkin_o=%b pixel_o=%0h required 1/80", etkin_o, pixel_o);
        end
        $display("duplicates: pixel_o=%0h", pixel_o);
        @(posedge clk); #1;
        checks++;
        if (etkin_o !== 1'b0) begin
            failures++;
            $display("FAIL dup_release: etkin_o=%b required 0", etkin_o);
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int n_out = 0;
        logic acc_now;
        hazir_i = 1'b0; etkin_i = 1'b1; resim = sira_pencere(0, 0);
        for (int c = 0; c < 130 && n_out < 12; c++) begin
            if (c == 30) begin
                checks++;
                if (n_acc != 10 || hazir_o !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_full: accepted=%0d hazir_o=%b required 10/0", n_acc, hazir_o);
                end
                hazir_i = 1'b1;
            end
            acc_now = etkin_i && hazir_o;
            if (etkin_o && hazir_i) begin
                checks++;
                if (pixel_o !== 8'(n_out * 16 + 4)) begin
                    failures++;
                    $display("FAIL bp_order: result %0d got %0d required %0d", n_out, pixel_o, n_out * 16 + 4);
                end
                $display("backpressure: result %0d pixel_o=%0d", n_out, pixel_o);
                n_out++;
            end
            @(posedge clk); #1;
            if (acc_now) n_acc++;
            etkin_i = (n_acc < 12);
            resim   = sira_pencere(0, n_acc);
        end
        etkin_i = 1'b0;
        checks++;
        if (n_acc != 12 || n_out != 12) begin
            failures++;
            $display("FAIL bp_count: accepted=%0d results=%0d required 12/12", n_acc, n_out);
        end
    endtask

    task automatic test_reset_mid();
        pen_t p;
        logic gordu;
        hazir_i = 1'b0;
        for (int n = 0; n < 5; n++) begin
            etkin_i = 1'b1; resim = sira_pencere(64, n);
            @(posedge clk); #1;
        end
        etkin_i = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (etkin_o !== 1'b1) begin
            failures++;
            $display("FAIL rmid_busy: etkin_o=%b required 1 before reset", etkin_o);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (etkin_o !== 1'b0 || pixel_o !== 8'd0 || hazir_o !== 1'b1) begin
            failures++;
            $display("FAIL rmid_reset: etkin_o=%b pixel_o=%0d hazir_o=%b required 0/0/1", etkin_o, pixel_o, hazir_o);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        p = '{8'd5, 8'd3, 8'd7, 8'd5, 8'd9, 8'd1, 8'd5, 8'd2, 8'd8};
        resim = paketle(p); etkin_i = 1'b1; hazir_i = 1'b1;
        @(posedge clk); #1;
        etkin_i = 1'b0;
        gordu = 1'b0;
        for (int c = 0; c < 20 && !gordu; c++) begin
            if (etkin_o) begin
                gordu = 1'b1;
                checks++;
                if (pixel_o !== 8'd5) begin
                    failures++;
                    $display("FAIL rmid_first: pixel_o=%0d required 5", pixel_o);
                end
                $display("reset_mid: first result pixel_o=%0d", pixel_o);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!gordu) begin
            failures++;
            $display("FAIL rmid_timeout: no result within 20 cycles, required one");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] beklenen;
        pen_t p;
        int n_acc = 0;
        int n_out = 0;
        int durak = 0;
        logic acc_now;
        hazir2_i = 1'b1; etkin2_i = 1'b1;
        for (int k = 0; k < 9; k++) p[k] = 8'($urandom_range(0, 7));
        resim2 = paketle(p);
        for (int c = 0; c < 1200 && n_out < 1000; c++) begin
            if (etkin2_i && n_acc > 0 && hazir2_o !== 1'b1) durak++;
            acc_now = etkin2_i && hazir2_o;
            if (acc_now) q.push_back(medyan(p));
            if (etkin2_o) begin
                checks++;
                beklenen = (q.size() > 0) ? q.pop_front() : 8'hXX;
                if (pixel2_o !== beklenen) begin
                    failures++;
                    $display("FAIL thru_result: result %0d got %0d required %0d", n_out, pixel2_o, beklenen);
                end
                $display("throughput: result %0d pixel_o=%0d", n_out, pixel2_o);
                n_out++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                n_acc++;
                for (int k = 0; k < 9; k++)
                    p[k] = (n_acc % 2 == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
                resim2 = paketle(p);
            end
            etkin2_i = (n_acc < 1000);
        end
        etkin2_i = 1'b0;
        checks++;
        if (durak != 0) begin
            failures++;
            $display("FAIL thru_stall: hazir_o low %0d cycles, required 0", durak);
        end
        checks++;
        if (n_out != 1000) begin
            failures++;
            $display("FAIL thru_count: results=%0d required 1000", n_out);
        end
    endtask

`ifdef MEDYAN_MINMAKS_EN
    task automatic test_modes();
        pen_t p;
        logic [7:0] beklenen [3];
        logic gordu;
        beklenen = '{8'd1, 8'd9, 8'd5};
        p = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        hazir_i = 1'b1;
        for (int m = 1; m <= 3; m++) begin
            resim = paketle(p); mod_s = 2'(m); etkin_i = 1'b1;
            @(posedge clk); #1;
            etkin_i = 1'b0; mod_s = 2'd0;
            gordu = 1'b0;
            for (int c = 0; c < 20 && !gordu; c++) begin
                if (etkin_o) begin
                    gordu = 1'b1;
                    checks++;
                    if (pixel_o !== beklenen[m-1]) begin
                        failures++;
                        $display("FAIL mode_%0d: pixel_o=%0d required %0d", m, pixel_o, beklenen[m-1]);
                    end
                    $display("mode %0d: pixel_o=%0d", m, pixel_o);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (!gordu) begin
                failures++;
                $display("FAIL mode_timeout: mode %0d gave no result", m);
            end
        end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        etkin_i = 1'b0; hazir_i = 1'b0; resim = '0;
        etkin2_i = 1'b0; hazir2_i = 1'b0; resim2 = '0;
`ifdef MEDYAN_MINMAKS_EN
        mod_s = 2'd0; mod2_s = 2'd0;
`endif
        #3;
        test_reset();
        test_late_match();
        test_duplicates();
        test_backpressure();
        test_reset_mid();
`ifdef MEDYAN_MINMAKS_EN
        test_modes();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
